alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Four-step ALU instruction sequencer: reads rb then rc from the register file,
// drives the external ALU, then writes the result back (or updates HI/LO for
// MUL/DIV) and signals completion with a one-cycle done pulse.
module alu_sequencer #(
  parameter logic [4:0] ADD_OP  = 5'b00011,
  parameter logic [4:0] SUB_OP  = 5'b00100,
  parameter logic [4:0] SHR_OP  = 5'b00101,
  parameter logic [4:0] SHRA_OP = 5'b00110,
  parameter logic [4:0] SHL_OP  = 5'b00111,
  parameter logic [4:0] ROR_OP  = 5'b01000,
  parameter logic [4:0] ROL_OP  = 5'b01001,
  parameter logic [4:0] AND_OP  = 5'b01010,
  parameter logic [4:0] OR_OP   = 5'b01011,
  parameter logic [4:0] MUL_OP  = 5'b01110,
  parameter logic [4:0] DIV_OP  = 5'b01111,
  parameter logic [4:0] NEG_OP  = 5'b10000,
  parameter logic [4:0] NOT_OP  = 5'b10001
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  output logic [3:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StT4} state_e;

  state_e      state_q;
  // Only opcode/ra/rb/rc are kept; the low 15 instruction bits are never used.
  logic [16:0] ir_q;
  logic [31:0] y_q, z_q, zhi_q, zlo_q;
  logic        is_legal, is_muldiv;
  logic        unused_ir_low;

  assign unused_ir_low = ^ir[14:0];

  // Opcode classification of the latched instruction.
  always_comb begin
    is_muldiv = (ir_q[16:12] == MUL_OP) || (ir_q[16:12] == DIV_OP);
    is_legal  = ir_q[16:12] inside {ADD_OP, SUB_OP, SHR_OP, SHRA_OP, SHL_OP, ROR_OP, ROL_OP,
                                    AND_OP, OR_OP, MUL_OP, DIV_OP, NEG_OP, NOT_OP};
  end

  // Register-file and ALU drive; everything is zero outside its active step.
  always_comb begin
    rf_raddr   = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    unique case (state_q)
      StT1: rf_raddr = ir_q[7:4];
      StT2: begin
        rf_raddr   = ir_q[3:0];
        alu_a      = y_q;
        alu_b      = rf_rdata;
        alu_opcode = ir_q[16:12];
      end
      StT3: begin
        if (is_legal && !is_muldiv) begin
          rf_we    = 1'b1;
          rf_waddr = ir_q[11:8];
          rf_wdata = z_q;
        end
      end
      default: ;
    endcase
  end

  // Sequencer state, operand/result latches, HI/LO and status pulses.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      ir_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          if (start) begin
            ir_q    <= ir[31:15];
            busy    <= 1'b1;
            state_q <= StT1;
          end
        end
        StT1: begin
          y_q     <= rf_rdata;
          state_q <= StT2;
        end
        StT2: begin
          z_q     <= alu_result;
          zhi_q   <= alu_hi;
          zlo_q   <= alu_lo;
          state_q <= StT3;
        end
        StT3: begin
          if (is_muldiv) begin
            hi_q <= zhi_q;
            lo_q <= zlo_q;
          end
          done    <= 1'b1;
          illegal <= !is_legal;
          state_q <= StT4;
        end
        StT4: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
